// File: rtl/act_buf_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// act_buf_pingpong_ctrl
//
// Ping-pong controller for the activation memory. The memory is split into
// two halves (buffers) of TOTAL_SIZE/2 bytes. While the host streams words
// into one half through the write port, the MAC array may compute on the other
// half. Buffers are filled and consumed strictly in fill order: ld_ptr and
// cmp_ptr each flip after every completed load / compute.
//
// Each buffer walks EMPTY -> LOADING -> FULL -> BUSY -> EMPTY and never takes
// any other transition. All grant decisions look only at registered state, so
// a buffer changed at one edge becomes eligible for the other side one cycle
// later at the earliest.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   load_req          host asks for a buffer to fill
//   load_grant        one-cycle pulse, a load has started
//   load_buf          buffer being loaded (meaningful while load_active)
//   load_active       a load is in progress
//   wr_valid/wr_ready write-word handshake (wr_ready == load_active)
//   wr_last           marks the final word of a load (only with wr_valid)
//   wr_data           write data
//   mem_we/mem_waddr/mem_wdata  byte-addressed memory write port
//   cmp_req           compute unit asks for a filled buffer
//   cmp_grant         one-cycle pulse, compute has started on a buffer
//   cmp_active        compute owns a buffer
//   cmp_base/cmp_len  byte base address and word count of the compute buffer
//   cmp_done          compute finished, releases its buffer
//   buf_full          bit i set while buffer i is FULL or BUSY
//   overflow_err      sticky: a load hit capacity without wr_last
// -----------------------------------------------------------------------------
module act_buf_pingpong_ctrl #(
  parameter int TOTAL_SIZE    = 16384,
  parameter int PORT_WIDTH    = 32,
  parameter int ADDR_W        = 14,
  parameter int WORDS_PER_BUF = 2048,
  parameter int LEN_W         = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  output logic                  load_grant,
  output logic                  load_buf,
  output logic                  load_active,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_last,
  input  logic [PORT_WIDTH-1:0] wr_data,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [PORT_WIDTH-1:0] mem_wdata,
  input  logic                  cmp_req,
  output logic                  cmp_grant,
  output logic                  cmp_active,
  output logic [ADDR_W-1:0]     cmp_base,
  output logic [LEN_W-1:0]      cmp_len,
  input  logic                  cmp_done,
  output logic [1:0]            buf_full,
  output logic                  overflow_err
);

  localparam int                BYTES_PER_WORD = PORT_WIDTH / 8;
  localparam int                HALF_BYTES     = TOTAL_SIZE / 2;
  localparam logic [ADDR_W-1:0] HALF_ADDR      = ADDR_W'(HALF_BYTES);
  localparam logic [LEN_W-1:0]  LAST_IDX       = LEN_W'(WORDS_PER_BUF - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2,
    ST_BUSY    = 2'd3
  } buf_state_t;

  // Per-buffer state and recorded fill length
  buf_state_t        r_state     [2];
  buf_state_t        w_state_nxt [2];
  logic [LEN_W-1:0]  r_len       [2];

  // Load side
  logic              r_ld_ptr;
  logic              r_load_grant;
  logic              r_load_active;
  logic              r_load_buf;
  logic [LEN_W-1:0]  r_count;
  logic              r_overflow;

  // Compute side
  logic              r_cmp_ptr;
  logic              r_cmp_grant;
  logic              r_cmp_active;
  logic [ADDR_W-1:0] r_cmp_base;
  logic [LEN_W-1:0]  r_cmp_len;

  // Decoded events for the current cycle
  logic              w_wr_accept;
  logic              w_at_capacity;
  logic              w_load_end;
  logic              w_cap_ovf;
  logic              w_load_start;
  logic              w_cmp_start;
  logic              w_cmp_release;
  logic [ADDR_W-1:0] w_buf_base;
  logic [ADDR_W-1:0] w_word_off;

  assign w_wr_accept   = wr_valid & r_load_active;
  assign w_at_capacity = (r_count == LAST_IDX);
  // A load ends on the marked word or on the word that fills the half.
  assign w_load_end    = w_wr_accept & (wr_last | w_at_capacity);
  assign w_cap_ovf     = w_wr_accept & w_at_capacity & ~wr_last;

  assign w_load_start  = load_req & ~r_load_active & (r_state[r_ld_ptr] == ST_EMPTY);
  assign w_cmp_start   = cmp_req & ~r_cmp_active & (r_state[r_cmp_ptr] == ST_FULL);
  assign w_cmp_release = cmp_done & r_cmp_active;

  // Per-buffer next state. The four events need mutually exclusive source
  // states, so at most one of them can move any given buffer in a cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_EMPTY:   if (w_load_start  && (r_ld_ptr   == 1'(i))) w_state_nxt[i] = ST_LOADING;
        ST_LOADING: if (w_load_end    && (r_load_buf == 1'(i))) w_state_nxt[i] = ST_FULL;
        ST_FULL:    if (w_cmp_start   && (r_cmp_ptr  == 1'(i))) w_state_nxt[i] = ST_BUSY;
        ST_BUSY:    if (w_cmp_release && (r_cmp_ptr  == 1'(i))) w_state_nxt[i] = ST_EMPTY;
        default:    w_state_nxt[i] = r_state[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Load sequencing: grant, word counter, completion and overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_ptr      <= 1'b0;
      r_load_grant  <= 1'b0;
      r_load_active <= 1'b0;
      r_load_buf    <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_len[0]      <= '0;
      r_len[1]      <= '0;
    end else begin
      r_load_grant <= w_load_start;
      if (w_load_start) begin
        r_load_active <= 1'b1;
        r_load_buf    <= r_ld_ptr;
        r_count       <= '0;
      end else begin
        if (w_wr_accept) begin
          r_count <= r_count + 1'b1;
        end
        if (w_load_end) begin
          r_load_active     <= 1'b0;
          r_ld_ptr          <= ~r_ld_ptr;
          r_len[r_load_buf] <= r_count + 1'b1;
        end
      end
      if (w_cap_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Compute hand-off: base/len are captured at grant and held after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmp_ptr    <= 1'b0;
      r_cmp_grant  <= 1'b0;
      r_cmp_active <= 1'b0;
      r_cmp_base   <= '0;
      r_cmp_len    <= '0;
    end else begin
      r_cmp_grant <= w_cmp_start;
      if (w_cmp_start) begin
        r_cmp_active <= 1'b1;
        r_cmp_base   <= r_cmp_ptr ? HALF_ADDR : '0;
        r_cmp_len    <= r_len[r_cmp_ptr];
      end else if (w_cmp_release) begin
        r_cmp_active <= 1'b0;
        r_cmp_ptr    <= ~r_cmp_ptr;
      end
    end
  end

  // Zero-latency write path: the byte address is the half base plus the
  // word index scaled to bytes.
  assign w_buf_base = r_load_buf ? HALF_ADDR : '0;
  assign w_word_off = ADDR_W'(r_count) * ADDR_W'(BYTES_PER_WORD);

  assign mem_we     = w_wr_accept;
  assign mem_waddr  = w_buf_base + w_word_off;
  assign mem_wdata  = wr_data;

  always_comb begin
    buf_full = 2'b00;
    for (int i = 0; i < 2; i++) begin
      buf_full[i] = (r_state[i] == ST_FULL) || (r_state[i] == ST_BUSY);
    end
  end

  assign load_grant   = r_load_grant;
  assign load_buf     = r_load_buf;
  assign load_active  = r_load_active;
  assign wr_ready     = r_load_active;
  assign cmp_grant    = r_cmp_grant;
  assign cmp_active   = r_cmp_active;
  assign cmp_base     = r_cmp_base;
  assign cmp_len      = r_cmp_len;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_act_buf_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for act_buf_pingpong_ctrl: directed scenarios with literal
// expectations followed by a randomized phase, all outputs compared every
// cycle against a transaction-level model (fill-order queue of buffers).
// -----------------------------------------------------------------------------
module tb_act_buf_pingpong_ctrl;

  localparam int TOTAL_SIZE    = 16384;
  localparam int PORT_WIDTH    = 32;
  localparam int ADDR_W        = 14;
  localparam int WORDS_PER_BUF = 2048;
  localparam int LEN_W         = 12;
  localparam int HALF          = TOTAL_SIZE / 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  load_req = 1'b0;
  logic                  load_grant;
  logic                  load_buf;
  logic                  load_active;
  logic                  wr_valid = 1'b0;
  logic                  wr_ready;
  logic                  wr_last = 1'b0;
  logic [PORT_WIDTH-1:0] wr_data = '0;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [PORT_WIDTH-1:0] mem_wdata;
  logic                  cmp_req = 1'b0;
  logic                  cmp_grant;
  logic                  cmp_active;
  logic [ADDR_W-1:0]     cmp_base;
  logic [LEN_W-1:0]      cmp_len;
  logic                  cmp_done = 1'b0;
  logic [1:0]            buf_full;
  logic                  overflow_err;

  act_buf_pingpong_ctrl #(
    .TOTAL_SIZE(TOTAL_SIZE), .PORT_WIDTH(PORT_WIDTH), .ADDR_W(ADDR_W),
    .WORDS_PER_BUF(WORDS_PER_BUF), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset),
    .load_req(load_req), .load_grant(load_grant), .load_buf(load_buf),
    .load_active(load_active),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last), .wr_data(wr_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cmp_req(cmp_req), .cmp_grant(cmp_grant), .cmp_active(cmp_active),
    .cmp_base(cmp_base), .cmp_len(cmp_len), .cmp_done(cmp_done),
    .buf_full(buf_full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: buffers waiting for compute sit in a queue in fill order;
  // a buffer is empty when it is neither being loaded, queued, nor computed on.
  // ---------------------------------------------------------------------------
  int fillq[$];
  int m_lens[2] = '{0, 0};
  bit m_load_on = 0, m_cmp_on = 0, m_lg = 0, m_cg = 0, m_ovf = 0;
  int m_load_buf = 0, m_cmp_buf = 0, m_next_load = 0, m_cnt = 0;
  int m_base = 0, m_len = 0;

  function automatic bit queued(int b);
    foreach (fillq[k]) if (fillq[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_empty(int b);
    return !(m_load_on && m_load_buf == b) && !queued(b) && !(m_cmp_on && m_cmp_buf == b);
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit acc, lend, lstart, cstart, crel;
    if (reset) begin
      fillq.delete();
      m_lens[0] = 0; m_lens[1] = 0;
      m_load_on = 0; m_cmp_on = 0; m_lg = 0; m_cg = 0; m_ovf = 0;
      m_load_buf = 0; m_cmp_buf = 0; m_next_load = 0; m_cnt = 0;
      m_base = 0; m_len = 0;
    end else begin
      acc    = wr_valid && m_load_on;
      lend   = acc && (wr_last || m_cnt == WORDS_PER_BUF - 1);
      lstart = load_req && !m_load_on && is_empty(m_next_load);
      cstart = cmp_req && !m_cmp_on && (fillq.size() > 0);
      crel   = cmp_done && m_cmp_on;
      m_lg = lstart;
      m_cg = cstart;
      if (cstart) begin
        m_cmp_buf = fillq.pop_front();
        m_cmp_on  = 1;
        m_base    = m_cmp_buf * HALF;
        m_len     = m_lens[m_cmp_buf];
      end else if (crel) begin
        m_cmp_on = 0;
      end
      if (lend) begin
        m_lens[m_load_buf] = m_cnt + 1;
        fillq.push_back(m_load_buf);
        m_load_on   = 0;
        m_next_load = 1 - m_next_load;
        if (!wr_last) m_ovf = 1;
      end else if (acc) begin
        m_cnt++;
      end
      if (lstart) begin
        m_load_on  = 1;
        m_load_buf = m_next_load;
        m_cnt      = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin : compare
    bit ewe;
    int efull;
    if (chk_en) begin
      ewe   = wr_valid && m_load_on;
      efull = 0;
      for (int b = 0; b < 2; b++)
        if (queued(b) || (m_cmp_on && m_cmp_buf == b)) efull += (1 << b);
      chk("load_grant",   int'(load_grant),   int'(m_lg));
      chk("load_active",  int'(load_active),  int'(m_load_on));
      chk("wr_ready",     int'(wr_ready),     int'(m_load_on));
      chk("mem_we",       int'(mem_we),       int'(ewe));
      if (m_load_on) chk("load_buf", int'(load_buf), m_load_buf);
      if (ewe) begin
        chk("mem_waddr", int'(mem_waddr), m_load_buf * HALF + 4 * m_cnt);
        chk("mem_wdata", int'(mem_wdata), int'(wr_data));
      end
      chk("cmp_grant",    int'(cmp_grant),    int'(m_cg));
      chk("cmp_active",   int'(cmp_active),   int'(m_cmp_on));
      chk("cmp_base",     int'(cmp_base),     m_base);
      chk("cmp_len",      int'(cmp_len),      m_len);
      chk("buf_full",     int'(buf_full),     efull);
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n words starting in the current cycle; checks the first few and
  // the final byte address against base + 4*k.
  task automatic write_words(input int n, input bit last, input int base, input string tag);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_last  = last && (k == n - 1);
      wr_data  = $urandom;
      @(negedge clk);
      if (k < 3 || k == n - 1) chk(tag, int'(mem_waddr), base + 4 * k);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  initial begin : stim
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_buf_full", int'(buf_full), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_cmp_len", int'(cmp_len), 0);
    tick();

    // First load: 3 words into buffer 0
    load_req = 1'b1;
    @(negedge clk);
    chk("t1_pre_grant", int'(load_grant), 0);
    tick();
    load_req = 1'b0;
    @(negedge clk);
    chk("t1_grant", int'(load_grant), 1);
    chk("t1_load_buf", int'(load_buf), 0);
    tick();
    write_words(3, 1'b1, 0, "t1_addr");
    @(negedge clk);
    chk("t1_buf_full", int'(buf_full), 1);
    chk("t1_load_active", int'(load_active), 0);
    chk("model_len0", m_lens[0], 3);
    tick();

    // Compute on buffer 0 while loading buffer 1 (both grants together)
    cmp_req = 1'b1;
    load_req = 1'b1;
    tick();
    cmp_req = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    chk("t2_cmp_grant", int'(cmp_grant), 1);
    chk("t2_cmp_base", int'(cmp_base), 0);
    chk("t2_cmp_len", int'(cmp_len), 3);
    chk("t2_load_grant", int'(load_grant), 1);
    chk("t2_load_buf", int'(load_buf), 1);
    tick();
    write_words(4, 1'b1, 8192, "t2_addr");
    @(negedge clk);
    chk("t2_buf_full", int'(buf_full), 3);
    tick();

    // Both buffers taken: load stalls until cmp_done frees buffer 0
    load_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall", int'(load_grant), 0);
      tick();
    end
    cmp_done = 1'b1;
    @(negedge clk);
    chk("t3_n0", int'(load_grant), 0);
    tick();
    cmp_done = 1'b0;
    @(negedge clk);
    chk("t3_n1", int'(load_grant), 0);
    tick();
    @(negedge clk);
    chk("t3_n2_grant", int'(load_grant), 1);
    chk("t3_n2_buf", int'(load_buf), 0);
    tick();
    load_req = 1'b0;

    // Capacity load without wr_last into buffer 0
    write_words(WORDS_PER_BUF, 1'b0, 0, "t4_addr");
    load_req = 1'b1;
    @(negedge clk);
    chk("t4_ovf", int'(overflow_err), 1);
    chk("t4_wr_ready", int'(wr_ready), 0);
    chk("t4_buf_full", int'(buf_full), 3);
    chk("t4_stall_full", int'(load_grant), 0);
    chk("model_ovf", int'(m_ovf), 1);
    tick();
    @(negedge clk);
    chk("t4_stall_full2", int'(load_grant), 0);
    tick();
    load_req = 1'b0;

    // Drain: buffer 1 (4 words) then buffer 0 (2048 words)
    cmp_req = 1'b1;
    tick();
    cmp_req = 1'b0;
    @(negedge clk);
    chk("t4_cg1", int'(cmp_grant), 1);
    chk("t4_base1", int'(cmp_base), 8192);
    chk("t4_len1", int'(cmp_len), 4);
    tick();
    cmp_done = 1'b1;
    tick();
    cmp_done = 1'b0;
    cmp_req = 1'b1;
    @(negedge clk);
    chk("t4_rel_active", int'(cmp_active), 0);
    chk("t4_base_hold", int'(cmp_base), 8192);
    tick();
    cmp_req = 1'b0;
    cmp_done = 1'b1;
    @(negedge clk);
    chk("t4_cg0", int'(cmp_grant), 1);
    chk("t4_base0", int'(cmp_base), 0);
    chk("t4_len0", int'(cmp_len), 2048);
    tick();
    cmp_done = 1'b0;
    @(negedge clk);
    chk("t4_all_empty", int'(buf_full), 0);
    tick();

    // Stray cmp_done and wr_last without wr_valid change nothing
    cmp_done = 1'b1;
    wr_last  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t6_buf_full", int'(buf_full), 0);
      chk("t6_cmp_active", int'(cmp_active), 0);
      chk("t6_load_active", int'(load_active), 0);
      tick();
    end
    cmp_done = 1'b0;
    wr_last  = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    @(negedge clk);
    chk("t6_grant", int'(load_grant), 1);
    chk("t6_ptr_kept", int'(load_buf), 1);
    tick();
    write_words(5, 1'b0, 8192, "t6_addr");

    // Reset in the middle of that load
    wr_valid = 1'b1;
    wr_data  = $urandom;
    reset    = 1'b1;
    #1;
    chk("t5_mem_we", int'(mem_we), 0);
    chk("t5_buf_full", int'(buf_full), 0);
    chk("t5_ovf", int'(overflow_err), 0);
    chk("t5_load_active", int'(load_active), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    @(negedge clk);
    chk("t5_grant", int'(load_grant), 1);
    chk("t5_buf0", int'(load_buf), 0);
    tick();
    write_words(3, 1'b1, 0, "t5_addr");

    // Randomized traffic, checked by the compare process every cycle
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 599) == 0);
      load_req = $urandom_range(0, 1) == 1;
      wr_valid = $urandom_range(0, 9) < 7;
      wr_last  = $urandom_range(0, 11) == 0;
      wr_data  = $urandom;
      cmp_req  = $urandom_range(0, 1) == 1;
      cmp_done = $urandom_range(0, 9) == 0;
      tick();
    end
    reset = 1'b0; load_req = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    cmp_req = 1'b0; cmp_done = 1'b0;
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
